ib_ram_update_writer: RTL

Iteration-update write engine for the IB-CNU function RAMs. It takes a stream of LUT words from the host/ROM side and drives the write port (page address, data, write enable) of every per-stage IB RAM. It walks every page of one multi-frame partition, stage by stage. It is the producer side of the `page_addr_ram` / `ram_write_data_*` / `ib_ram_we` / `write_clk` port that the CNU stage blocks consume.

---
 rtl/ib_ram_pkg.sv | 34 +++
 rtl/ib_wr_addr_gen.sv | 60 ++++++
 rtl/ib_ram_update_writer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ib_ram_pkg.sv
// Shared definitions for the IB RAM update writer: default geometry,
// derived page/stage counts, LUT word width and the writer FSM state type.
package ib_ram_pkg;

    // Default geometry of the IB-CNU function RAMs
    localparam int ENTRY_ADDR_DEF      = 4;
    localparam int MULTI_FRAME_NUM_DEF = 2;
    localparam int BANK_NUM_DEF        = 2;
    localparam int LUT_PORT_SIZE_DEF   = 2;
    localparam int STAGE_NUM_DEF       = 4;

    // One LUT word spans every bank of a RAM row
    localparam int LUT_WORD_W = LUT_PORT_SIZE_DEF * BANK_NUM_DEF;

    // Width needed to count n items, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pages per partition: the address MSB(s) select the frame partition
    function automatic int page_num_of(input int entry_addr, input int frames);
        return 1 << (entry_addr - cnt_width(frames));
    endfunction

    localparam int PAGE_NUM_DEF = page_num_of(ENTRY_ADDR_DEF, MULTI_FRAME_NUM_DEF);
    localparam int STAGE_W_DEF  = cnt_width(STAGE_NUM_DEF);
    localparam int PASS_WORDS   = PAGE_NUM_DEF * STAGE_NUM_DEF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } wr_state_e;

endpackage

// File: rtl/ib_wr_addr_gen.sv
// Page/stage walker for the IB RAM update writer. Steps the page counter on
// every accepted beat, carries into the stage counter on page wrap, decodes
// the stage into a one-hot write-enable pattern and flags the final beat.
module ib_wr_addr_gen
    import ib_ram_pkg::*;
#(
    parameter int PAGE_W    = 3,
    parameter int STAGE_NUM = 4,
    parameter int STAGE_W   = cnt_width(STAGE_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [PAGE_W-1:0]    page_cnt,
    output logic [STAGE_NUM-1:0] stage_onehot,
    output logic                 last_beat
);

    localparam int PAGE_MAX = (1 << PAGE_W) - 1;

    logic [STAGE_W-1:0] stage_cnt_r;
    logic               page_max_s;
    logic               stage_max_s;

    assign page_max_s  = (page_cnt == PAGE_W'(PAGE_MAX));
    assign stage_max_s = (stage_cnt_r == STAGE_W'(STAGE_NUM - 1));

    // Page counter with carry into the stage counter on page wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_cnt    <= {PAGE_W{1'b0}};
            stage_cnt_r <= {STAGE_W{1'b0}};
        end else if (clear) begin
            page_cnt    <= {PAGE_W{1'b0}};
            stage_cnt_r <= {STAGE_W{1'b0}};
        end else if (advance) begin
            if (page_max_s) begin
                page_cnt    <= {PAGE_W{1'b0}};
                stage_cnt_r <= stage_max_s ? {STAGE_W{1'b0}} : stage_cnt_r + STAGE_W'(1);
            end else begin
                page_cnt    <= page_cnt + PAGE_W'(1);
                stage_cnt_r <= stage_cnt_r;
            end
        end else begin
            page_cnt    <= page_cnt;
            stage_cnt_r <= stage_cnt_r;
        end
    end

    // One-hot stage select and last-beat flag for the current position
    always_comb begin
        stage_onehot = {STAGE_NUM{1'b0}};
        for (int i = 0; i < STAGE_NUM; i++) begin
            stage_onehot[i] = (stage_cnt_r == STAGE_W'(i));
        end
        last_beat = page_max_s && stage_max_s;
    end

endmodule

// File: rtl/ib_ram_update_writer.sv
// Iteration-update write engine for the IB-CNU function RAMs. Accepts a
// stream of LUT words and writes every page of one frame partition, stage by
// stage, through a one-cycle-latency registered RAM write port.
// Optional feature macro: IB_RAM_WR_CHECKSUM_EN adds wr_checksum, the running
// XOR of all words written in the current pass.
module ib_ram_update_writer
    import ib_ram_pkg::*;
#(
    parameter int ENTRY_ADDR      = 4,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int BANK_NUM        = 2,
    parameter int LUT_PORT_SIZE   = 2,
    parameter int STAGE_NUM       = 4
) (
    input  logic                              write_clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              frame_offset,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
    input  logic                              src_valid,
    output logic                              src_ready,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
    output logic [STAGE_NUM-1:0]              ib_ram_we,
    output logic                              busy,
    output logic                              done
`ifdef IB_RAM_WR_CHECKSUM_EN
   ,output logic [LUT_PORT_SIZE*BANK_NUM-1:0] wr_checksum
`endif
);

    localparam int WORD_W  = LUT_PORT_SIZE * BANK_NUM;
    // Partition select occupies the address MSB(s); the rest indexes pages
    localparam int FRAME_W = cnt_width(MULTI_FRAME_NUM);
    localparam int PAGE_W  = ENTRY_ADDR - FRAME_W;

    wr_state_e            state_r;
    logic                 frame_offset_r;
    logic                 start_accept_s;
    logic                 beat_s;
    logic [PAGE_W-1:0]    page_cnt_s;
    logic [STAGE_NUM-1:0] stage_onehot_s;
    logic                 last_beat_s;

    // Handshake is a pure decode of the state register, never of src_valid
    assign src_ready      = (state_r == LOAD);
    assign busy           = (state_r == LOAD);
    assign start_accept_s = (state_r == IDLE) && start;
    assign beat_s         = (state_r == LOAD) && src_valid;

    ib_wr_addr_gen #(
        .PAGE_W    (PAGE_W),
        .STAGE_NUM (STAGE_NUM),
        .STAGE_W   (cnt_width(STAGE_NUM))
    ) u_addr_gen (
        .clk          (write_clk),
        .rst          (rst),
        .clear        (start_accept_s),
        .advance      (beat_s),
        .page_cnt     (page_cnt_s),
        .stage_onehot (stage_onehot_s),
        .last_beat    (last_beat_s)
    );

    // Writer FSM plus the registered RAM write port
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            frame_offset_r <= 1'b0;
            page_addr_ram  <= {ENTRY_ADDR{1'b0}};
            ram_write_data <= {WORD_W{1'b0}};
            ib_ram_we      <= {STAGE_NUM{1'b0}};
            done           <= 1'b0;
        end else begin
            // Enables and done are single-cycle; address and data hold
            ib_ram_we <= {STAGE_NUM{1'b0}};
            done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r        <= LOAD;
                        frame_offset_r <= frame_offset;
                    end else begin
                        state_r        <= IDLE;
                    end
                end
                LOAD: begin
                    if (src_valid) begin
                        ram_write_data <= src_data;
                        page_addr_ram  <= {FRAME_W'(frame_offset_r), page_cnt_s};
                        ib_ram_we      <= stage_onehot_s;
                        done           <= last_beat_s;
                        state_r        <= last_beat_s ? IDLE : LOAD;
                    end else begin
                        state_r        <= LOAD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef IB_RAM_WR_CHECKSUM_EN
    // Running XOR of the words written in the current pass
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            wr_checksum <= {WORD_W{1'b0}};
        end else if (start_accept_s) begin
            wr_checksum <= {WORD_W{1'b0}};
        end else if (beat_s) begin
            wr_checksum <= wr_checksum ^ src_data;
        end else begin
            wr_checksum <= wr_checksum;
        end
    end
`endif

endmodule
